// File: rtl/clk_div_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : clk_div_ramp_ctrl
// Ramps a clock divider's divisor toward a target in clamped steps, each write
// aligned to a divider period boundary tracked by a cycle-accurate mirror.
// Rev     : 1.0
// ============================================================================
module clk_div_ramp_ctrl #(
  parameter logic [7:0] STEP          = 8'd1,
  parameter logic [7:0] DWELL_PERIODS = 8'd1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_div,
  output logic [7:0] div,
  output logic       busy,
  output logic       done
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RAMP = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_div;
  logic [7:0] w_div_nxt;
  logic [7:0] r_target;
  logic [7:0] w_target_nxt;
  logic [7:0] r_dwell;
  logic [7:0] w_dwell_nxt;
  logic       r_pending;
  logic       w_pending_nxt;
  logic       r_done;
  logic       w_done_nxt;
  logic [7:0] r_applied;
  logic [8:0] r_mcnt;
  logic       w_top;
  logic [7:0] w_gap;
  logic [7:0] w_step;

  assign w_top  = (r_mcnt == ({1'b0, r_applied} + 9'd1));
  assign w_gap  = (r_target > r_div) ? (r_target - r_div) : (r_div - r_target);
  assign w_step = (w_gap < STEP) ? w_gap : STEP;

  // Shadow of the divider's period counter; it latches div only at period end.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mcnt    <= 9'd1;
      r_applied <= 8'd0;
    end else if (w_top) begin
      r_mcnt    <= 9'd1;
      r_applied <= r_div;
    end else begin
      r_mcnt    <= r_mcnt + 9'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_div     <= 8'd0;
      r_target  <= 8'd0;
      r_dwell   <= 8'd0;
      r_pending <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_div     <= w_div_nxt;
      r_target  <= w_target_nxt;
      r_dwell   <= w_dwell_nxt;
      r_pending <= w_pending_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_div_nxt     = r_div;
    w_target_nxt  = r_target;
    w_dwell_nxt   = r_dwell;
    w_pending_nxt = r_pending;
    w_done_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_target_nxt = req_div;
          if (req_div == r_div) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt   = S_RAMP;
            w_dwell_nxt   = 8'd0;
            w_pending_nxt = 1'b0;
          end
        end
      end
      S_RAMP: begin
        // A step becomes live one period after its write, then dwells.
        if (w_top) begin
          if (r_pending) begin
            w_dwell_nxt   = DWELL_PERIODS;
            w_pending_nxt = 1'b0;
          end else if (r_dwell != 8'd0) begin
            w_dwell_nxt = r_dwell - 8'd1;
          end else if (r_div != r_target) begin
            w_div_nxt     = (r_target > r_div) ? (r_div + w_step) : (r_div - w_step);
            w_pending_nxt = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state == S_RAMP);
  assign div       = r_div;
  assign done      = r_done;

endmodule
`default_nettype wire
